operator_sequencer: RTL and testbench

Sequences the phase/modulation pipeline. On each sample tick it emits every voice-operator ID once, one per clock, with that voice's note-on flag, into the phase generator / stage_modulator chain. It also owns host configuration traffic: it buffers algorithm-word and note-on writes and applies them only between sample frames, so an algorithm word never changes while its voice is in flight.

---
 rtl/operator_sequencer_pkg.sv | 51 +++++
 rtl/operator_sequencer_config_fifo.sv | 65 ++++++
 rtl/operator_sequencer.sv | 164 ++++++++++++++++
 tb/tb_operator_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operator_sequencer_pkg.sv
// Shared definitions for the operator sequencer.
// Holds the frame geometry, the voice-operator ID layout, the host
// configuration target encoding, the buffered config-write entry format and
// the sequencer state encoding. It also provides helpers that split and build
// voice-operator IDs.
package operator_sequencer_pkg;

    localparam int NUM_VOICES        = 32;
    localparam int NUM_OPERATORS     = 8;
    localparam int CONFIG_FIFO_DEPTH = 4;

    localparam int VOICE_W             = $clog2(NUM_VOICES);
    localparam int OPERATOR_W          = $clog2(NUM_OPERATORS);
    localparam int VOICE_OPERATOR_ID_W = VOICE_W + OPERATOR_W;
    localparam int NUM_IDS             = NUM_VOICES * NUM_OPERATORS;
    localparam int ALGORITHM_WORD_W    = 11;
    localparam int CONFIG_DATA_W       = 16;

    typedef logic [VOICE_OPERATOR_ID_W-1:0] voice_operator_id_t;
    typedef logic [VOICE_W-1:0]             voice_id_t;
    typedef logic [OPERATOR_W-1:0]          operator_id_t;

    typedef enum logic {
        CONFIG_TARGET_ALGORITHM = 1'b0,
        CONFIG_TARGET_NOTEON    = 1'b1
    } config_target_t;

    typedef struct packed {
        config_target_t               target;
        voice_operator_id_t           addr;
        logic [CONFIG_DATA_W-1:0]     data;
    } config_entry_t;

    localparam int CONFIG_ENTRY_W = $bits(config_entry_t);

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    // The voice occupies the upper bits of an ID (voice-major ordering).
    function automatic voice_id_t get_voice_id(input voice_operator_id_t id);
        return id[VOICE_OPERATOR_ID_W-1 -: VOICE_W];
    endfunction

    function automatic voice_operator_id_t make_voice_operator_id(input voice_id_t voice,
                                                                  input operator_id_t op);
        return {voice, op};
    endfunction

endpackage

// File: rtl/operator_sequencer_config_fifo.sv
// Synchronous FIFO buffering host configuration writes.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset; empties the FIFO
//   push       write push_data (ignored while full)
//   push_data  entry to store
//   pop        remove the head entry (ignored while empty)
//   pop_data   current head entry
//   full       registered; no free entry
//   empty      registered; no stored entry
// Depth must be a power of two so the pointers wrap by natural overflow.
module config_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    assign pop_data   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (PTR_W+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so clearing data is wasted logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/operator_sequencer.sv
// Operator sequencer: issues every voice-operator ID once per sample frame,
// one per clock, with its voice's note-on flag, and applies buffered host
// configuration writes only while no frame is in flight.
// Ports:
//   i_Clock, i_Reset_n                 clock, synchronous active-low reset
//   i_SampleTick                       starts a frame (ignored and flagged while running)
//   i_ConfigWrite{Valid,Target,Addr,Data} / o_ConfigWriteReady  host write channel
//   o_AlgorithmWriteEnable, o_ConfigWriteAddr, o_ConfigWriteData  algorithm memory write
//   o_Valid, o_VoiceOperator, o_NoteOn, o_FrameDone               pipeline issue stream
//   o_Overrun, i_OverrunClear          sticky tick-while-running flag and its clear
module operator_sequencer
    import operator_sequencer_pkg::*;
(
    input  logic                           i_Clock,
    input  logic                           i_Reset_n,
    input  logic                           i_SampleTick,
    input  logic                           i_ConfigWriteValid,
    output logic                           o_ConfigWriteReady,
    input  logic                           i_ConfigWriteTarget,
    input  logic [VOICE_OPERATOR_ID_W-1:0] i_ConfigWriteAddr,
    input  logic [CONFIG_DATA_W-1:0]       i_ConfigWriteData,
    output logic                           o_AlgorithmWriteEnable,
    output logic [VOICE_OPERATOR_ID_W-1:0] o_ConfigWriteAddr,
    output logic [CONFIG_DATA_W-1:0]       o_ConfigWriteData,
    output logic                           o_Valid,
    output logic [VOICE_OPERATOR_ID_W-1:0] o_VoiceOperator,
    output logic                           o_NoteOn,
    output logic                           o_FrameDone,
    output logic                           o_Overrun,
    input  logic                           i_OverrunClear
);

    localparam voice_operator_id_t LAST_ID = VOICE_OPERATOR_ID_W'(NUM_IDS - 1);

    seq_state_t               state, state_next;
    voice_operator_id_t       vo_id, vo_id_next;
    voice_operator_id_t       vo_id_inc;
    logic                     valid, valid_next;
    logic                     note_on, note_on_next;
    logic                     frame_done, frame_done_next;
    logic                     alg_we, alg_we_next;
    voice_operator_id_t       cfg_addr, cfg_addr_next;
    logic [CONFIG_DATA_W-1:0] cfg_data, cfg_data_next;
    logic [NUM_VOICES-1:0]    note_flags, note_flags_next;
    logic                     overrun, overrun_next;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      fifo_push;
    config_entry_t             push_entry;
    config_entry_t             head;
    logic [CONFIG_ENTRY_W-1:0] head_bits;

    assign o_ConfigWriteReady = !fifo_full;
    assign fifo_push          = i_ConfigWriteValid && !fifo_full;
    assign push_entry.target  = config_target_t'(i_ConfigWriteTarget);
    assign push_entry.addr    = i_ConfigWriteAddr;
    assign push_entry.data    = i_ConfigWriteData;
    assign head               = config_entry_t'(head_bits);
    assign vo_id_inc          = vo_id + 1'b1;

    config_fifo #(
        .DEPTH (CONFIG_FIFO_DEPTH),
        .WIDTH (CONFIG_ENTRY_W)
    ) u_config_fifo (
        .clk       (i_Clock),
        .rst_n     (i_Reset_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        vo_id_next      = vo_id;
        valid_next      = 1'b0;
        note_on_next    = 1'b0;
        frame_done_next = 1'b0;
        alg_we_next     = 1'b0;
        cfg_addr_next   = cfg_addr;
        cfg_data_next   = cfg_data;
        note_flags_next = note_flags;
        fifo_pop        = 1'b0;
        // A tick in RUN sets the flag after the clear, so set wins.
        overrun_next    = overrun && !i_OverrunClear;

        unique case (state)
            SEQ_IDLE: begin
                if (i_SampleTick) begin
                    // The tick cycle never drains, so an algorithm strobe can
                    // never coincide with the first issued ID.
                    state_next      = SEQ_RUN;
                    vo_id_next      = '0;
                    valid_next      = 1'b1;
                    note_on_next    = note_flags[0];
                    frame_done_next = (NUM_IDS == 1);
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.target == CONFIG_TARGET_ALGORITHM) begin
                        alg_we_next   = 1'b1;
                        cfg_addr_next = head.addr;
                        cfg_data_next = head.data;
                    end else begin
                        note_flags_next[get_voice_id(head.addr)] = head.data[0];
                    end
                end
            end
            SEQ_RUN: begin
                if (i_SampleTick) overrun_next = 1'b1;
                if (vo_id == LAST_ID) begin
                    state_next = SEQ_IDLE;
                end else begin
                    vo_id_next      = vo_id_inc;
                    valid_next      = 1'b1;
                    note_on_next    = note_flags[get_voice_id(vo_id_inc)];
                    frame_done_next = (vo_id_inc == LAST_ID);
                end
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state      <= SEQ_IDLE;
            vo_id      <= '0;
            valid      <= 1'b0;
            note_on    <= 1'b0;
            frame_done <= 1'b0;
            alg_we     <= 1'b0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
            note_flags <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            vo_id      <= vo_id_next;
            valid      <= valid_next;
            note_on    <= note_on_next;
            frame_done <= frame_done_next;
            alg_we     <= alg_we_next;
            cfg_addr   <= cfg_addr_next;
            cfg_data   <= cfg_data_next;
            note_flags <= note_flags_next;
            overrun    <= overrun_next;
        end
    end

    assign o_Valid                = valid;
    assign o_VoiceOperator        = vo_id;
    assign o_NoteOn               = note_on;
    assign o_FrameDone            = frame_done;
    assign o_AlgorithmWriteEnable = alg_we;
    assign o_ConfigWriteAddr      = cfg_addr;
    assign o_ConfigWriteData      = cfg_data;
    assign o_Overrun              = overrun;

endmodule

// File: tb/tb_operator_sequencer.sv
// Self-checking bench for operator_sequencer: directed scenarios plus
// randomized config traffic checked against a frame-level reference model
// (note-on flag array and an ordered queue of expected algorithm writes).
module tb_operator_sequencer;
    import operator_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_target = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        alg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        valid;
    logic [7:0]  vo_id;
    logic        note_on;
    logic        frame_done;
    logic        overrun;
    logic        overrun_clear = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          flags_m [NUM_VOICES];
    logic [23:0] exp_q [$];
    logic [23:0] obs_q [$];
    int          both_high = 0;
    int          run_len   = 0;
    int          max_run   = 0;

    always #5 clk = ~clk;

    operator_sequencer dut (
        .i_Clock                (clk),
        .i_Reset_n              (rst_n),
        .i_SampleTick           (tick),
        .i_ConfigWriteValid     (wr_valid),
        .o_ConfigWriteReady     (wr_ready),
        .i_ConfigWriteTarget    (wr_target),
        .i_ConfigWriteAddr      (wr_addr),
        .i_ConfigWriteData      (wr_data),
        .o_AlgorithmWriteEnable (alg_we),
        .o_ConfigWriteAddr      (cfg_addr),
        .o_ConfigWriteData      (cfg_data),
        .o_Valid                (valid),
        .o_VoiceOperator        (vo_id),
        .o_NoteOn               (note_on),
        .o_FrameDone            (frame_done),
        .o_Overrun              (overrun),
        .i_OverrunClear         (overrun_clear)
    );

    // Records every algorithm-memory write and tracks strobe run lengths.
    always @(negedge clk) begin
        if (rst_n && alg_we) begin
            obs_q.push_back({cfg_addr, cfg_data});
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (alg_we && valid) both_high = both_high + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards apply at the next edge and
    // outputs read afterwards reflect the edge just passed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input bit target, input logic [7:0] addr, input logic [15:0] data);
        int w;
        wr_valid  = 1'b1;
        wr_target = target;
        wr_addr   = addr;
        wr_data   = data;
        w = 0;
        while (!wr_ready && w < 400) begin
            step();
            w++;
        end
        if (w >= 400) check("write_ready_timeout", 0, 1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_frame_done();
        int w;
        w = 0;
        while (!frame_done && w < NUM_IDS + 20) begin
            step();
            w++;
        end
        check("frame_done_seen", frame_done, 1);
    endtask

    // Tick from IDLE and check the whole issue stream against the model.
    task automatic run_frame(input string tag);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            check($sformatf("%s_id%0d", tag, i),
                  {valid, vo_id, note_on, frame_done},
                  {1'b1, 8'(i), 1'(flags_m[i / NUM_OPERATORS]), 1'(i == NUM_IDS - 1)});
            if (i < NUM_IDS - 1) step();
        end
        step();
        check({tag, "_valid_after"}, valid, 0);
    endtask

    task automatic compare_alg(input string tag);
        check({tag, "_alg_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_alg_entry"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          accepted;
        int          idx;
        int          w;
        bit          r;
        bit          fd_seen;
        bit          tgt;
        logic [7:0]  a;
        logic [15:0] d;

        foreach (flags_m[v]) flags_m[v] = 1'b0;

        // Reset and idle.
        repeat (3) step();
        check("rst_valid", valid, 0);
        check("rst_alg_we", alg_we, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_vo_id", vo_id, 0);
        check("rst_cfg_addr", cfg_addr, 0);
        check("rst_cfg_data", cfg_data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_valid", valid, 0);
            check("idle_ready", wr_ready, 1);
        end

        // Note-on voice 3, then a full frame.
        write_cfg(1'b1, 8'(3 * NUM_OPERATORS), 16'h0001);
        flags_m[3] = 1'b1;
        repeat (5) step();
        run_frame("noteon3");

        // Tick, then five algorithm writes while running.
        tick = 1'b1;
        step();
        tick = 1'b0;
        wr_valid = 1'b1; wr_target = 1'b0; wr_addr = 8'd9; wr_data = 16'h02A5;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("fifo_ready_5th", wr_ready, 0);
            if (wr_ready) accepted++;
            step();
        end
        wr_valid = 1'b0;
        check("fifo_accepted", accepted, 4);
        repeat (4) exp_q.push_back({8'd9, 16'h02A5});
        max_run = 0;
        wait_frame_done();
        check("no_alg_in_run", obs_q.size(), 0);
        step();
        check("alg_we_first_idle", alg_we, 0);
        repeat (8) step();
        check("drain_consecutive", max_run, 4);
        check("both_high", both_high, 0);
        compare_alg("burst");

        // Overrun set, clear, and set-wins.
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_frame_done();
        check("overrun_pre", overrun, 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("overrun_set", overrun, 1);
        check("overrun_tick_ignored", valid, 0);
        step();
        check("overrun_no_restart", valid, 0);
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        check("overrun_cleared", overrun, 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) step();
        tick = 1'b1; overrun_clear = 1'b1;
        step();
        tick = 1'b0; overrun_clear = 1'b0;
        check("overrun_set_wins", overrun, 1);
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        check("overrun_clear_in_run", overrun, 0);
        wait_frame_done();
        step();
        check("overrun_frame_end", valid, 0);

        // Continuous pushes across the drain; order must survive pointer wrap.
        tick = 1'b1;
        step();
        tick = 1'b0;
        max_run = 0;
        idx = 0;
        w = 0;
        wr_valid = 1'b1; wr_target = 1'b0;
        while (idx < 16 && w < 1000) begin
            wr_addr = 8'(8'h40 + idx);
            wr_data = 16'(16'h1000 + idx * 16'h0111);
            r = wr_ready;
            step();
            if (r) begin
                exp_q.push_back({wr_addr, wr_data});
                idx++;
            end
            w++;
        end
        wr_valid = 1'b0;
        check("stream_pushed", idx, 16);
        repeat (10) step();
        check("stream_no_gaps", max_run, 16);
        compare_alg("stream");

        // Randomized config traffic between frames.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
                tgt = 1'($urandom_range(1, 0));
                a   = 8'($urandom);
                d   = 16'($urandom);
                write_cfg(tgt, a, d);
                if (tgt) flags_m[a / NUM_OPERATORS] = d[0];
                else     exp_q.push_back({a, d});
            end
            // Guarantee at least one voice is on so the frame check is not trivial.
            write_cfg(1'b1, 8'(f * 5 * NUM_OPERATORS + 2), 16'h0001);
            flags_m[f * 5] = 1'b1;
            repeat (10) step();
            run_frame($sformatf("rand%0d", f));
        end
        compare_alg("rand");
        check("both_high_end", both_high, 0);

        // Reset in mid-frame.
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (100) step();
        check("midreset_at_100", vo_id, 100);
        rst_n = 1'b0;
        step();
        check("midreset_valid", valid, 0);
        check("midreset_frame_done", frame_done, 0);
        rst_n = 1'b1;
        foreach (flags_m[v]) flags_m[v] = 1'b0;
        fd_seen = 1'b0;
        for (int i = 0; i < NUM_IDS + 5; i++) begin
            step();
            if (frame_done || valid) fd_seen = 1'b1;
        end
        check("midreset_silent", fd_seen, 0);
        run_frame("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
